// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction-bus requester of the in-order pipeline.
// Emits {raw_instr, pc} records to decode over a valid/ready handshake.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   ireq_valid/ireq_addr   instruction request (address = current PC)
//   iresp_addr_ok          bus accepted the request address this cycle
//   iresp_data_ok/_data    instruction word returned this cycle
//   redirect_valid/_pc     branch/jump/flush target from later stages
//   out_valid/out_ready    handshake to decode
//   out_data               {raw_instr[95:64], pc[63:0]}
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out_data
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_q, pend_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;

  logic [63:0] tgt;
  logic        data_ret;
  fetch_data_t rec;

  assign tgt = redirect_pc & ~64'h3;

  // data_ok only counts once the address has been accepted,
  // either earlier (S_WAIT) or in this same cycle (S_REQ).
  assign data_ret =
    ((state_q == S_REQ) & iresp_addr_ok & iresp_data_ok) |
    ((state_q == S_WAIT) & iresp_data_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= PC_RESET;
      pend_q  <= '0;
      kill_q  <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    unique case (state_q)
      S_REQ, S_WAIT: begin
        if (data_ret) begin
          if (redirect_valid) begin
            pc_d    = tgt;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (kill_q) begin
            pc_d    = pend_q;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = iresp_data;
            state_d = S_OUT;
          end
        end else begin
          if ((state_q == S_REQ) && iresp_addr_ok)
            state_d = S_WAIT;
          // In-flight transaction cannot be cancelled;
          // its data is dropped on return instead.
          if (redirect_valid) begin
            kill_d = 1'b1;
            pend_d = tgt;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign rec.raw_instr = instr_q;
  assign rec.pc        = pc_q;

  assign ireq_valid = (state_q == S_REQ) & ~reset;
  assign ireq_addr  = pc_q;
  assign out_valid  = (state_q == S_OUT);
  assign out_data   = out_valid ? rec : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// Transaction-level model checked every cycle plus literal spot checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
  );

  always #5 clk = ~clk;

  // Model: the fetch stream as transactions. fetch_pc is the next
  // address to fetch, or the PC of the held instruction.
  logic [63:0] m_pc      = 64'h8000_0000;
  bit          m_hold    = 0;
  logic [31:0] m_word    = '0;
  bit          m_flight  = 0;
  bit          m_discard = 0;
  logic [63:0] m_target  = '0;

  function automatic logic [63:0] align(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

  always @(posedge clk) begin
    bit ret;
    if (reset) begin
      m_pc      = 64'h8000_0000;
      m_hold    = 0;
      m_flight  = 0;
      m_discard = 0;
    end else if (m_hold) begin
      if (redirect_valid) begin
        m_pc   = align(redirect_pc);
        m_hold = 0;
      end else if (out_ready) begin
        m_pc   = m_pc + 64'd4;
        m_hold = 0;
      end
    end else begin
      ret = m_flight ? iresp_data_ok : (iresp_addr_ok && iresp_data_ok);
      if (ret) begin
        m_flight = 0;
        if (redirect_valid) begin
          m_pc      = align(redirect_pc);
          m_discard = 0;
        end else if (m_discard) begin
          m_pc      = m_target;
          m_discard = 0;
        end else begin
          m_hold = 1;
          m_word = iresp_data;
        end
      end else begin
        if (!m_flight && iresp_addr_ok) m_flight = 1;
        if (redirect_valid) begin
          m_discard = 1;
          m_target  = align(redirect_pc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [95:0] got,
                     input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit ev;
    ev = !reset && !m_hold && !m_flight;
    chk("m_ireq_valid", {95'd0, ireq_valid}, {95'd0, ev});
    if (ev) chk("m_ireq_addr", {32'd0, ireq_addr}, {32'd0, m_pc});
    chk("m_out_valid", {95'd0, out_valid}, {95'd0, m_hold});
    chk("m_out_data", out_data, m_hold ? {m_word, m_pc} : 96'd0);
  end

  task automatic set_in(input bit rst, input bit ao, input bit dk,
                        input logic [31:0] d, input bit rv,
                        input logic [63:0] rp, input bit rdy);
    reset          = rst;
    iresp_addr_ok  = ao;
    iresp_data_ok  = dk;
    iresp_data     = d;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_out_data", out_data, 96'd0);
    chk("rst_ireq_valid", {95'd0, ireq_valid}, 96'd0);

    // zero-latency fetch
    set_in(0, 1, 1, 32'h0000_0013, 0, 0, 1);
    #1;
    chk("t1_req_v", {95'd0, ireq_valid}, 96'd1);
    chk("t1_req_a", {32'd0, ireq_addr}, {32'd0, 64'h8000_0000});
    tick();
    chk("t1_out_v", {95'd0, out_valid}, 96'd1);
    chk("t1_out_d", out_data, {32'h0000_0013, 64'h8000_0000});
    chk("t1_req_off", {95'd0, ireq_valid}, 96'd0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("t1_next", {32'd0, ireq_addr}, {32'd0, 64'h8000_0004});

    // backpressure
    set_in(0, 1, 1, 32'h0010_0093, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold", out_data, {32'h0010_0093, 64'h8000_0004});
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("t2_adv", {32'd0, ireq_addr}, {32'd0, 64'h8000_0008});

    // slow bus: addr_ok then data_ok three cycles later
    set_in(0, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t3_wait", {95'd0, ireq_valid}, 96'd0);
    set_in(0, 0, 1, 32'h0020_0113, 0, 0, 0);
    tick();
    chk("t3_out", out_data, {32'h0020_0113, 64'h8000_0008});
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();

    // redirect during wait
    set_in(0, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 64'h8000_1000, 0);
    tick();
    set_in(0, 0, 1, 32'hdead_beef, 0, 0, 0);
    tick();
    chk("t4_drop", {95'd0, out_valid}, 96'd0);
    chk("t4_tgt", {32'd0, ireq_addr}, {32'd0, 64'h8000_1000});

    // redirect beats out_ready in S_OUT, misaligned target
    set_in(0, 1, 1, 32'h0030_0193, 0, 0, 0);
    tick();
    chk("t5_out", out_data, {32'h0030_0193, 64'h8000_1000});
    set_in(0, 0, 0, 0, 1, 64'h8000_2002, 1);
    tick();
    chk("t5_drop", {95'd0, out_valid}, 96'd0);
    chk("t5_tgt", {32'd0, ireq_addr}, {32'd0, 64'h8000_2000});

    // two redirects while one request outstanding
    set_in(0, 1, 0, 0, 1, 64'h8000_3000, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 64'h8000_4000, 0);
    tick();
    set_in(0, 0, 1, 32'hbad0_0bad, 0, 0, 0);
    tick();
    chk("t6_tgt", {32'd0, ireq_addr}, {32'd0, 64'h8000_4000});
    set_in(0, 1, 1, 32'h0040_0213, 0, 0, 1);
    tick();
    chk("t6_out", out_data, {32'h0040_0213, 64'h8000_4000});
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();

    // redirect together with data_ok
    set_in(0, 1, 1, 32'h1111_1111, 1, 64'h8000_5000, 1);
    tick();
    chk("t7_drop", {95'd0, out_valid}, 96'd0);
    chk("t7_tgt", {32'd0, ireq_addr}, {32'd0, 64'h8000_5000});

    // PC wraps modulo 2^64
    set_in(0, 1, 1, 0, 1, 64'hffff_ffff_ffff_fffc, 0);
    tick();
    set_in(0, 1, 1, 32'h0000_0013, 0, 0, 1);
    tick();
    chk("t8_top", out_data, {32'h0000_0013, 64'hffff_ffff_ffff_fffc});
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("t8_wrap", {32'd0, ireq_addr}, 96'd0);

    // reset while waiting, late data_ok ignored
    set_in(0, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t9_rst_req", {95'd0, ireq_valid}, 96'd0);
    set_in(0, 0, 1, 32'hbad0_0bad, 0, 0, 0);
    #1;
    chk("t9_addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0000});
    tick();
    chk("t9_late", {95'd0, out_valid}, 96'd0);
    chk("t9_req", {95'd0, ireq_valid}, 96'd1);
    set_in(0, 1, 1, 32'h0000_0073, 0, 0, 1);
    tick();
    chk("t9_out", out_data, {32'h0000_0073, 64'h8000_0000});
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
